// File: rtl/para.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

    localparam int unsigned CNT_WIDTH = 16;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;

    // The requester that did not win, used to rotate round-robin priority.
    function automatic req_e other_req(input req_e r);
        return (r == REQ_ALU) ? REQ_LSU : REQ_ALU;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard of destination registers with outstanding writes.
// Register 0 is never busy; a same-cycle set beats a clear.
module rf_scoreboard #(
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);

    localparam int unsigned NREG = 2 ** ADDR_WIDTH;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    always_comb begin
        busy_next = busy;
        if (clr_en) busy_next[clr_addr] = 1'b0;
        if (set_en) busy_next[set_addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) busy <= '0;
        else        busy <= busy_next;
    end

    // Queries see only committed state; no bypass of this cycle's updates.
    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester (ALU/LSU) register-file writeback arbiter with busy scoreboard.
// Define RF_ARB_RR_EN for round-robin conflict resolution; default is LSU priority.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  rsv_valid,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    logic                  both_valid;
    req_e                  winner;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] xfer_addr;
    logic [DATA_WIDTH-1:0] xfer_data;
    logic                  wr_en;

`ifdef RF_ARB_RR_EN
    req_e prio;
`endif

    assign both_valid = alu_valid && lsu_valid;

    // Grant selection and combinational ready; reset blocks all transfers.
    always_comb begin
        winner = REQ_ALU;
        if (both_valid) begin
`ifdef RF_ARB_RR_EN
            winner = prio;
`else
            winner = REQ_LSU;
`endif
        end else if (lsu_valid) begin
            winner = REQ_LSU;
        end
        alu_ready = reset && alu_valid && (winner == REQ_ALU);
        lsu_ready = reset && lsu_valid && (winner == REQ_LSU);
        xfer      = alu_ready || lsu_ready;
        xfer_addr = (winner == REQ_LSU) ? lsu_addr : alu_addr;
        xfer_data = (winner == REQ_LSU) ? lsu_data : alu_data;
        wr_en     = xfer && (xfer_addr != '0);
    end

`ifdef RF_ARB_RR_EN
    // Priority rotates only when a conflict is actually resolved.
    always_ff @(posedge clock) begin
        if (!reset)                  prio <= REQ_ALU;
        else if (both_valid && xfer) prio <= other_req(winner);
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            wen <= wr_en;
            if (wr_en) begin
                waddr <= xfer_addr;
                wdata <= xfer_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)
            conflict_cnt <= '0;
        else if (both_valid && (conflict_cnt != '1))
            conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .set_en   (rsv_valid),
        .set_addr (rsv_addr),
        .clr_en   (wr_en),
        .clr_addr (xfer_addr),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy)
    );

endmodule
